exec_sequencer: RTL and testbench

//  Multi-cycle control FSM for the LEGv8 execute datapath. Sequences fetch, decode, execute, memory and write-back.

---
 rtl/exec_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle LEGv8 control sequencer: walks FETCH/DECODE/EXEC/MEM/WB, drives
// datapath controls, handshakes with both memories, counts retirements, traps on faults.
module exec_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [10:0]      opcode,
   input  logic             zero,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             ir_write,
   output logic             dmem_req,
   output logic [1:0]       ALUSrc,
   output logic [1:0]       ALUOp,
   output logic             B,
   output logic             BZ,
   output logic             BNZ,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             pc_write,
   output logic             PCSrc,
   output logic             busy,
   output logic             trap,
   output logic [1:0]       trap_code,
   output logic [CNT_W-1:0] retired
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      C_ILL, C_R, C_I, C_LD, C_ST, C_CBZ, C_CBNZ, C_B
   } cls_t;

   state_t          state, state_nxt;
   cls_t            cls_q, dec_cls, cls_eff;
   logic [TW-1:0]   tcnt, tcnt_nxt;
   logic [1:0]      code_nxt;
   logic            expired;
   state_t          boundary;

   function automatic cls_t classify(input logic [10:0] op);
      cls_t c;
      c = C_ILL;
      if (op == 11'b10001011000 || op == 11'b11001011000 ||
          op == 11'b10001010000 || op == 11'b10101010000)
         c = C_R;
      else if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100)
         c = C_I;
      else if (op == 11'b11111000010)
         c = C_LD;
      else if (op == 11'b11111000000)
         c = C_ST;
      else if (op[10:3] == 8'b10110100)
         c = C_CBZ;
      else if (op[10:3] == 8'b10110101)
         c = C_CBNZ;
      else if (op[10:5] == 6'b000101)
         c = C_B;
      return c;
   endfunction

   assign dec_cls  = classify(opcode);
   assign expired  = (tcnt == TW'(MEM_TIMEOUT - 1));
   assign boundary = run ? S_FETCH : S_IDLE;

   // The opcode is decoded live during DECODE and held in cls_q afterwards
   assign cls_eff  = (state == S_DECODE) ? dec_cls : cls_q;

   always_comb begin
      state_nxt = state;
      code_nxt  = trap_code;
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      dmem_req  = 1'b0;
      ALUSrc    = 2'b00;
      ALUOp     = 2'b00;
      B         = 1'b0;
      BZ        = 1'b0;
      BNZ       = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      pc_write  = 1'b0;
      PCSrc     = 1'b0;
      busy      = (state != S_IDLE) && (state != S_TRAP);
      trap      = (state == S_TRAP);

      if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
         case (cls_eff)
            C_R:            begin ALUSrc = 2'b00; ALUOp = 2'b10; end
            C_I:            begin ALUSrc = 2'b10; ALUOp = 2'b10; end
            C_LD, C_ST:     begin ALUSrc = 2'b01; ALUOp = 2'b00; end
            C_CBZ, C_CBNZ:  begin ALUSrc = 2'b00; ALUOp = 2'b01; end
            default:        begin ALUSrc = 2'b00; ALUOp = 2'b00; end
         endcase
      end

      if (state == S_DECODE || state == S_EXEC) begin
         B   = (cls_eff == C_B);
         BZ  = (cls_eff == C_CBZ);
         BNZ = (cls_eff == C_CBNZ);
      end

      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            // An ack in the expiry cycle still counts as a successful fetch
            if (imem_ack) begin
               ir_write  = 1'b1;
               state_nxt = S_DECODE;
            end else if (expired) begin
               state_nxt = S_TRAP;
               code_nxt  = 2'b10;
            end
         end
         S_DECODE: begin
            if (dec_cls == C_ILL) begin
               state_nxt = S_TRAP;
               code_nxt  = 2'b01;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls_q)
               C_B, C_CBZ, C_CBNZ: begin
                  pc_write  = 1'b1;
                  PCSrc     = B | (BZ & zero) | (BNZ & ~zero);
                  state_nxt = boundary;
               end
               C_LD, C_ST: state_nxt = S_MEM;
               C_R, C_I:   state_nxt = S_WB;
               default: begin
                  state_nxt = S_TRAP;
                  code_nxt  = 2'b01;
               end
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            MemRead  = (cls_q == C_LD);
            MemWrite = (cls_q == C_ST);
            if (dmem_ack) begin
               if (cls_q == C_ST) begin
                  pc_write  = 1'b1;
                  state_nxt = boundary;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (expired) begin
               state_nxt = S_TRAP;
               code_nxt  = 2'b11;
            end
         end
         S_WB: begin
            RegWrite  = 1'b1;
            MemtoReg  = (cls_q == C_LD);
            pc_write  = 1'b1;
            state_nxt = boundary;
         end
         default: begin
            state_nxt = S_TRAP;
         end
      endcase
   end

   // Wait counter restarts on every state change and only runs while waiting on memory
   always_comb begin
      tcnt_nxt = '0;
      if (state_nxt == state && (state == S_FETCH || state == S_MEM))
         tcnt_nxt = tcnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cls_q     <= C_ILL;
         tcnt      <= '0;
         trap_code <= 2'b00;
         retired   <= '0;
      end else begin
         state     <= state_nxt;
         tcnt      <= tcnt_nxt;
         trap_code <= code_nxt;
         if (state == S_DECODE)
            cls_q <= dec_cls;
         if (pc_write)
            retired <= retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized bench for exec_sequencer: an instruction-level model derives the expected
// per-cycle control vector, retirement count and trap code from the opcode classes.
module tb_exec_sequencer;

   localparam int MEM_T = 4;
   localparam int CW    = 4;

   localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4,
                  K_CBZ = 5, K_CBNZ = 6, K_B = 7;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_CBNZ = 11'b10110101010;
   localparam logic [10:0] OP_B    = 11'b00010110011;
   localparam logic [10:0] OP_ADDI = 11'b10010001001;
   localparam logic [10:0] OP_BAD  = 11'b11111111111;

   logic          clk = 1'b0;
   logic          rst_n, run, zero, imem_ack, dmem_ack;
   logic [10:0]   opcode;
   logic          imem_req, ir_write, dmem_req, B, BZ, BNZ, MemRead, MemWrite;
   logic          MemtoReg, RegWrite, pc_write, PCSrc, busy, trap;
   logic [1:0]    ALUSrc, ALUOp, trap_code;
   logic [CW-1:0] retired;
   logic [17:0]   ctl;

   int            n_chk = 0;
   int            n_err = 0;

   logic [CW-1:0] m_ret;
   logic [1:0]    m_code;
   bit            m_trap, m_idle;

   logic [10:0]   t_val [0:10];
   logic [10:0]   t_msk [0:10];
   int            t_kind [0:10];

   always #5 clk = ~clk;

   exec_sequencer #(.MEM_TIMEOUT(MEM_T), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
      .ir_write(ir_write), .dmem_req(dmem_req), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
      .B(B), .BZ(BZ), .BNZ(BNZ), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .pc_write(pc_write), .PCSrc(PCSrc),
      .busy(busy), .trap(trap), .trap_code(trap_code), .retired(retired)
   );

   assign ctl = {imem_req, ir_write, dmem_req, ALUSrc, ALUOp, B, BZ, BNZ, MemRead,
                 MemWrite, MemtoReg, RegWrite, pc_write, PCSrc, busy, trap};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] mk(input logic ireq, irw, dreq, input logic [1:0] asrc, aop,
                                      input logic b, bz, bnz, mr, mw, mtr, rw, pcw, pcs, bsy, trp);
      return {ireq, irw, dreq, asrc, aop, b, bz, bnz, mr, mw, mtr, rw, pcw, pcs, bsy, trp};
   endfunction

   task automatic init_tables();
      t_val[0]  = 11'b10001011000; t_msk[0]  = 11'h7FF; t_kind[0]  = K_R;
      t_val[1]  = 11'b11001011000; t_msk[1]  = 11'h7FF; t_kind[1]  = K_R;
      t_val[2]  = 11'b10001010000; t_msk[2]  = 11'h7FF; t_kind[2]  = K_R;
      t_val[3]  = 11'b10101010000; t_msk[3]  = 11'h7FF; t_kind[3]  = K_R;
      t_val[4]  = 11'b10010001000; t_msk[4]  = 11'h7FE; t_kind[4]  = K_I;
      t_val[5]  = 11'b11010001000; t_msk[5]  = 11'h7FE; t_kind[5]  = K_I;
      t_val[6]  = 11'b11111000010; t_msk[6]  = 11'h7FF; t_kind[6]  = K_LD;
      t_val[7]  = 11'b11111000000; t_msk[7]  = 11'h7FF; t_kind[7]  = K_ST;
      t_val[8]  = 11'b10110100000; t_msk[8]  = 11'h7F8; t_kind[8]  = K_CBZ;
      t_val[9]  = 11'b10110101000; t_msk[9]  = 11'h7F8; t_kind[9]  = K_CBNZ;
      t_val[10] = 11'b00010100000; t_msk[10] = 11'h7E0; t_kind[10] = K_B;
   endtask

   function automatic int ref_kind(input logic [10:0] op);
      for (int i = 0; i < 11; i++)
         if ((op & t_msk[i]) == t_val[i]) return t_kind[i];
      return K_ILL;
   endfunction

   // One clock: drive inputs mid-cycle, then compare the outputs for that cycle
   task automatic cyc(input logic ia, da, z, r, input logic [17:0] exp, input string tag);
      @(negedge clk);
      imem_ack = ia; dmem_ack = da; zero = z; run = r;
      #1;
      chk({tag, "_ctl"}, 32'(ctl), 32'(exp));
      chk({tag, "_ret"}, 32'(retired), 32'(m_ret));
      chk({tag, "_code"}, 32'(trap_code), 32'(m_code));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      #1;
      chk("rst_ctl", 32'(ctl), 32'(0));
      chk("rst_ret", 32'(retired), 32'(0));
      chk("rst_code", 32'(trap_code), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      m_ret = '0; m_code = 2'b00; m_trap = 0; m_idle = 1;
   endtask

   task automatic exec_one(input logic [10:0] op, input logic z, input int ilat,
                           input int dlat, input logic rl, input bit abort);
      int         kind;
      logic [1:0] asrc, aop;
      logic       b, bz, bnz, pcs, ack, ld, st;
      kind = ref_kind(op);
      opcode = op;
      case (kind)
         K_R:            begin asrc = 2'b00; aop = 2'b10; end
         K_I:            begin asrc = 2'b10; aop = 2'b10; end
         K_LD, K_ST:     begin asrc = 2'b01; aop = 2'b00; end
         K_CBZ, K_CBNZ:  begin asrc = 2'b00; aop = 2'b01; end
         default:        begin asrc = 2'b00; aop = 2'b00; end
      endcase
      b = (kind == K_B); bz = (kind == K_CBZ); bnz = (kind == K_CBNZ);
      ld = (kind == K_LD); st = (kind == K_ST);

      if (m_idle) begin
         cyc(0, 0, z, 1, 18'd0, "idle");
         m_idle = 0;
      end
      for (int k = 1; k <= MEM_T; k++) begin
         if (k == ilat) begin
            cyc(1, 0, z, 1, mk(1,1,0,2'b00,2'b00,0,0,0,0,0,0,0,0,0,1,0), "fetch_ack");
            break;
         end
         cyc(0, 0, z, 1, mk(1,0,0,2'b00,2'b00,0,0,0,0,0,0,0,0,0,1,0), "fetch");
         if (k == MEM_T) begin
            m_trap = 1; m_code = 2'b10;
            return;
         end
      end

      if (kind == K_ILL) begin
         cyc(0, 0, z, rl, mk(0,0,0,2'b00,2'b00,0,0,0,0,0,0,0,0,0,1,0), "decode_ill");
         m_trap = 1; m_code = 2'b01;
         return;
      end
      cyc(0, 0, z, rl, mk(0,0,0,asrc,aop,b,bz,bnz,0,0,0,0,0,0,1,0), "decode");

      if (b || bz || bnz) begin
         pcs = b | (bz & z) | (bnz & ~z);
         cyc(0, 0, z, rl, mk(0,0,0,asrc,aop,b,bz,bnz,0,0,0,0,1,pcs,1,0), "exec_br");
      end else begin
         cyc(0, 0, z, rl, mk(0,0,0,asrc,aop,0,0,0,0,0,0,0,0,0,1,0), "exec");
      end
      if (abort) begin
         #2 rst_n = 1'b0; run = 1'b0;
         #1;
         chk("abort_ctl", 32'(ctl), 32'(0));
         chk("abort_ret", 32'(retired), 32'(0));
         @(negedge clk);
         rst_n = 1'b1;
         m_ret = '0; m_code = 2'b00; m_idle = 1;
         return;
      end
      if (b || bz || bnz) begin
         m_ret++;
         if (!rl) m_idle = 1;
         return;
      end

      if (ld || st) begin
         for (int k = 1; k <= MEM_T; k++) begin
            ack = (k == dlat);
            cyc(0, ack, z, rl, mk(0,0,1,asrc,aop,0,0,0,ld,st,0,0,ack & st,0,1,0), "mem");
            if (ack) begin
               if (st) begin
                  m_ret++;
                  if (!rl) m_idle = 1;
                  return;
               end
               break;
            end
            if (k == MEM_T) begin
               m_trap = 1; m_code = 2'b11;
               return;
            end
         end
      end

      cyc(0, 0, z, rl, mk(0,0,0,asrc,aop,0,0,0,0,0,ld,1,1,0,1,0), "wb");
      m_ret++;
      if (!rl) m_idle = 1;
   endtask

   task automatic handle_trap();
      for (int i = 0; i < 3; i++)
         cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 18'd1, "trap_hold");
      do_reset();
   endtask

   task automatic step(input logic [10:0] op, input logic z, input int ilat,
                       input int dlat, input logic rl, input bit abort);
      exec_one(op, z, ilat, dlat, rl, abort);
      if (m_trap) handle_trap();
   endtask

   initial begin
      logic [10:0] op;
      int          sel;
      init_tables();
      rst_n = 1'b0; run = 1'b0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      opcode = '0;
      m_ret = '0; m_code = 2'b00; m_trap = 0; m_idle = 1;
      #2;
      chk("por_ctl", 32'(ctl), 32'(0));
      chk("por_ret", 32'(retired), 32'(0));
      chk("por_code", 32'(trap_code), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      step(OP_ADD,  0, 1, 0, 1, 0);
      step(OP_LDUR, 0, 1, 3, 1, 0);
      step(OP_STUR, 0, 2, 1, 1, 0);
      step(OP_CBZ,  1, 1, 0, 1, 0);
      step(OP_CBZ,  0, 1, 0, 1, 0);
      step(OP_CBNZ, 1, 1, 0, 1, 0);
      step(OP_CBNZ, 0, 1, 0, 1, 0);
      step(OP_B,    0, 1, 0, 1, 0);
      step(OP_ADDI, 1, 1, 0, 1, 0);
      step(OP_BAD,  0, 1, 0, 1, 0);
      step(OP_LDUR, 0, 1, 0, 1, 0);
      step(OP_LDUR, 0, 1, 4, 1, 0);
      step(OP_ADD,  0, 4, 0, 1, 0);
      step(OP_ADD,  0, 0, 0, 1, 0);
      step(OP_LDUR, 0, 1, 2, 0, 0);
      step(OP_STUR, 0, 1, 3, 0, 0);
      step(OP_B,    0, 1, 0, 1, 1);
      for (int i = 0; i < 20; i++)
         step(OP_ADD, 0, 1, 0, 1, 0);

      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            op = 11'($urandom);
         end else begin
            sel = $urandom_range(0, 10);
            op  = t_val[sel] | (11'($urandom) & ~t_msk[sel]);
         end
         step(op, 1'($urandom),
              ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, MEM_T),
              ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, MEM_T),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
